// File: rtl/ram_sp_ctrl.sv
// Single-port RAM with byte enables, registered read and post-reset clear.
// Optional per-word even parity when RAM_SP_PARITY_EN is defined.
module ram_sp_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    chip_select,
  input  logic                    we,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    data_valid,
`ifdef RAM_SP_PARITY_EN
  output logic                    parity_error,
`endif
  output logic                    ready
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH / 8;
  localparam int CW    = ADDR_WIDTH + 1;

  typedef enum logic {
    S_CLEAR,
    S_IDLE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CW-1:0]           clear_cnt;
  logic [CW-1:0]           clear_cnt_next;

  logic [DATA_WIDTH-1:0]   mem [DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic                    mem_we;
  logic                    rd_en;

  assign ready   = (state == S_IDLE);
  assign rd_word = mem[address];

  // Bytes not enabled keep their stored value.
  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NB; i++) begin
      if (byte_en[i]) begin
        merged[8*i +: 8] = data_in[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_next     = state;
    clear_cnt_next = clear_cnt;
    mem_we         = 1'b0;
    rd_en          = 1'b0;
    wr_addr        = address;
    wr_data        = merged;
    unique case (state)
      S_CLEAR: begin
        mem_we         = 1'b1;
        wr_addr        = clear_cnt[ADDR_WIDTH-1:0];
        wr_data        = CLEAR_VALUE;
        clear_cnt_next = clear_cnt + CW'(1);
        if (clear_cnt == CW'(DEPTH - 1)) begin
          state_next = S_IDLE;
        end
      end
      S_IDLE: begin
        if (chip_select) begin
          mem_we = we;
          rd_en  = !we;
        end
      end
      default: begin
        state_next = S_CLEAR;
      end
    endcase
  end

  always_ff @(negedge clock) begin
    if (mem_we && !reset) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef RAM_SP_PARITY_EN
  logic [DEPTH-1:0] par_mem;
  logic             par_bad;

  // Even parity: word bits plus stored bit must xor to zero.
  assign par_bad = ^{rd_word, par_mem[address]};

  always_ff @(negedge clock) begin
    if (mem_we && !reset) begin
      par_mem[wr_addr] <= ^wr_data;
    end
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      parity_error <= 1'b0;
    end else begin
      parity_error <= rd_en && par_bad;
    end
  end
`endif

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_CLEAR;
      clear_cnt  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      state      <= state_next;
      clear_cnt  <= clear_cnt_next;
      data_valid <= rd_en;
      if (rd_en) begin
        data_out <= rd_word;
      end
    end
  end

endmodule

// File: doc/ram_sp_ctrl.md
Name: ram_sp_ctrl

Overview:
- Parametrised single-port synchronous RAM with controller; next generation of the team's 32x32 scratch memory.
- Adds configurable width and depth, per-byte write enables, a registered read with a valid strobe, and a hardware clear sequence after reset.
- Sits on the datapath memory bus in place of fixed-size RAMs; a request is accepted only while ready is high.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width in bits; DEPTH = 2**ADDR_WIDTH words.
- CLEAR_VALUE, 0, word value written to every location during the clear sequence (DATA_WIDTH bits).

Ports:
- clock  input  1  system clock; all sequential logic acts on the falling edge.
- reset  input  1  asynchronous, active-high reset.
- chip_select  input  1  request strobe; sampled on the falling edge.
- we  input  1  1 = write, 0 = read; qualified by chip_select.
- address  input  ADDR_WIDTH  word address.
- data_in  input  DATA_WIDTH  write data.
- byte_en  input  DATA_WIDTH/8  per-byte write enable; bit i covers data bits [8i+7:8i].
- data_out  output  DATA_WIDTH  registered read data.
- data_valid  output  1  one-cycle strobe; data_out holds new read data.
- ready  output  1  high when the controller accepts requests; low during clear.

Behaviour:
- Reset (asynchronous, while high): data_out=0, data_valid=0, ready=0, clear counter=0, FSM=CLEAR. Memory contents are not reset directly.
- FSM states:
  - CLEAR: on each falling edge, writes CLEAR_VALUE to mem[clear_cnt] and increments clear_cnt. After writing address DEPTH-1, goes to IDLE. Duration is exactly DEPTH falling edges after reset deasserts. ready=0 throughout.
  - IDLE: ready=1. Accepted request = chip_select && ready at a falling edge.
- Write (we=1):
  - mem[address] bytes with byte_en[i]=1 take data_in; other bytes unchanged.
  - byte_en=0 is a legal no-op.
  - data_valid stays 0; data_out unchanged.
- Read (we=0):
  - data_out <= mem[address] and data_valid <= 1 on the same falling edge; latency 1 cycle from request to valid.
  - byte_en is ignored.
- data_valid:
  - Is 1 for exactly one cycle per accepted read.
  - Back-to-back reads give continuous valid with new data each cycle.
  - data_out holds the last read value until the next read.
- Read of an address written on the previous edge returns the new data. Single port, so there is no same-edge read/write conflict.
- chip_select while ready=0 is ignored: no write, no valid, and the request is not queued.
- Reset asserted mid-clear or mid-operation: immediately returns to the reset values and restarts CLEAR from address 0 when released.
- Address wrap: clear_cnt is ADDR_WIDTH+1 bits; the terminal condition is clear_cnt == DEPTH-1 being written, with no wrap to re-clear.

Optional Feature:
- Macro: RAM_SP_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit computed from the final merged word on every write, including clear and partial byte writes.
  - Each read recomputes parity; an added output port parity_error (output, 1) is registered alongside data_valid and is high for that cycle if stored parity mismatches.
  - parity_error resets to 0.
- Undefined: no parity storage, no parity_error port; behaviour otherwise identical.

Test Plan:
- Release reset with DEPTH=32 -> ready low for exactly 32 falling edges then high; reads of addresses 0, 17, 31 return 0x00000000.
- Write 0xDEADBEEF to addr 5 with byte_en=4'b1111, then read addr 5 -> data_out=0xDEADBEEF with data_valid high exactly one cycle after the read request.
- Write 0x11223344 with byte_en=4'b0101 over 0xAABBCCDD at addr 9, then read -> 0xAA22CC44.
- Assert chip_select with we=1 to addr 3 while ready=0 during clear -> after clear, addr 3 reads 0; no data_valid seen during clear.
- Assert reset when clear_cnt=12, release -> ready low for a full 32 further edges; all locations read CLEAR_VALUE.
- With RAM_SP_PARITY_EN: write 0x00000001, force flip of a stored bit, read -> parity_error=1 with data_valid; an unforced read gives parity_error=0.
